noise_avg_filter: RTL

Downstream consumer of the 24-bit noise generator. Pulls one sample at a time through a request/valid handshake and smooths it with a power-of-two moving-average low-pass filter. Hands each filtered sample to the audio codec write port through a ready/write handshake. Result: band-limited noise, written to both codec channels.

---
 rtl/noise_avg_filter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/noise_avg_filter.sv
// noise_avg_filter
//   Pulls signed samples from the noise generator one at a time over a
//   request/valid handshake. Smooths them with a 2^LOG2_TAPS-tap moving
//   average. Writes each result to both codec channels over a ready/write
//   handshake.
//
//   Optional build macro: NOISE_AVG_GAIN_EN. When it is defined, the block
//   adds a 3-bit `gain` port, and the average is arithmetically shifted
//   right by `gain` bits before it is output.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   sample_in/sample_valid  sample from the generator, consumed only in REQ
//   sample_req              high only in REQ (generator enable)
//   audio_write_ready       codec FIFO has space, sampled only in WAIT
//   audio_write             one-cycle write strobe (WRITE state)
//   audio_left/right        filtered sample, held from OUT to the next OUT
//   gain                    attenuation shift (NOISE_AVG_GAIN_EN only)
module noise_avg_filter #(
    parameter int DATA_WIDTH = 24,
    parameter int LOG2_TAPS  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef NOISE_AVG_GAIN_EN
    input  logic [2:0]            gain,
`endif
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_req,
    input  logic                  audio_write_ready,
    output logic                  audio_write,
    output logic [DATA_WIDTH-1:0] audio_left,
    output logic [DATA_WIDTH-1:0] audio_right
);

    localparam int TAPS  = 1 << LOG2_TAPS;
    localparam int SUM_W = DATA_WIDTH + LOG2_TAPS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACC,
        S_OUT,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t state, state_next;

    logic        [DATA_WIDTH-1:0]           x;
    logic        [TAPS-1:0][DATA_WIDTH-1:0] line;
    logic        [LOG2_TAPS-1:0]            ptr;
    logic signed [SUM_W-1:0]                sum;
    logic signed [SUM_W-1:0]                x_ext;
    logic signed [SUM_W-1:0]                old_ext;
    logic signed [DATA_WIDTH-1:0]           avg;
    logic signed [DATA_WIDTH-1:0]           result;

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        sample_req  = 1'b0;
        audio_write = 1'b0;
        case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ: begin
                sample_req = 1'b1;
                if (sample_valid) state_next = S_ACC;
            end
            S_ACC:   state_next = S_OUT;
            S_OUT:   state_next = S_WAIT;
            S_WAIT:  if (audio_write_ready) state_next = S_WRITE;
            S_WRITE: begin
                audio_write = 1'b1;
                state_next  = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    // Sign-extend the operands to the accumulator width. The running sum
    // of 2^LOG2_TAPS samples then cannot overflow.
    assign x_ext   = {{LOG2_TAPS{x[DATA_WIDTH-1]}}, x};
    assign old_ext = {{LOG2_TAPS{line[ptr][DATA_WIDTH-1]}}, line[ptr]};

    // Dropping the low LOG2_TAPS bits of a two's complement value is the
    // floor division (arithmetic shift). The remaining DATA_WIDTH bits
    // always hold the exact result.
    assign avg = sum[SUM_W-1:LOG2_TAPS];

`ifdef NOISE_AVG_GAIN_EN
    assign result = avg >>> gain;
`else
    assign result = avg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            line        <= '0;
            ptr         <= '0;
            sum         <= '0;
            audio_left  <= '0;
            audio_right <= '0;
        end else begin
            if (state == S_REQ && sample_valid) x <= sample_in;
            if (state == S_ACC) begin
                sum       <= sum + x_ext - old_ext;
                line[ptr] <= x;
                ptr       <= ptr + LOG2_TAPS'(1);
            end
            if (state == S_OUT) begin
                audio_left  <= result;
                audio_right <= result;
            end
        end
    end

endmodule
